// File: rtl/dmem_bridge.sv
// Data-memory bridge between the CPU dmem port and a local word array: req/ready handshake,
// configurable wait states, byte/half/word access with extension, and range/alignment faults.
module dmem_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH       = 2048,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    rdata_q;

  logic           we_q;
  logic [1:0]     size_q;
  logic           sext_q;
  logic [AW-1:0]  idx_q;
  logic [1:0]     lane_q;
  logic [31:0]    wdata_q;
  logic           fault_q;

  logic [31:0]    mem [DEPTH];

  logic [31:0]    off;
  logic           reqFault;
  logic           capture;
  logic [31:0]    memWord;
  logic [31:0]    storeWord;
  logic [31:0]    loadWord;
  logic [7:0]     loadByte;
  logic [15:0]    loadHalf;

  // Addresses below the base wrap to huge offsets, so one range compare covers both ends.
  assign off = addr - BASE_ADDR;

  always_comb begin
    reqFault = 1'b0;
    if (size == 2'b11)
      reqFault = 1'b1;
    if ({1'b0, off} >= LIMIT)
      reqFault = 1'b1;
    if ((size == 2'b01) && addr[0])
      reqFault = 1'b1;
    if ((size == 2'b10) && (addr[1:0] != 2'b00))
      reqFault = 1'b1;
  end

  assign capture = (state_q == S_IDLE) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (reqFault) begin
            state_d = S_RESP;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = S_ACCESS;
        else
          cnt_d = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_ACCESS) && !we_q)
        rdata_q <= loadWord;
    end
  end

  // Operands are frozen at acceptance; later changes on the request bus have no effect.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else if (capture) begin
      we_q    <= we;
      size_q  <= size;
      sext_q  <= sign_ext;
      idx_q   <= off[AW+1:2];
      lane_q  <= off[1:0];
      wdata_q <= wdata;
      fault_q <= reqFault;
    end
  end

  assign memWord = mem[idx_q];

  // Partial stores merge into the current word so untouched lanes survive.
  always_comb begin
    storeWord = memWord;
    case (size_q)
      2'b00:   storeWord[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   storeWord[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: storeWord = wdata_q;
    endcase
  end

  always_comb begin
    loadByte = memWord[{lane_q, 3'b000} +: 8];
    loadHalf = memWord[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   loadWord = {{24{sext_q & loadByte[7]}}, loadByte};
      2'b01:   loadWord = {{16{sext_q & loadHalf[15]}}, loadHalf};
      default: loadWord = memWord;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if ((state_q == S_ACCESS) && we_q)
      mem[idx_q] <= storeWord;
  end

  assign rdata = rdata_q;
  assign ready = (state_q == S_RESP);
  assign fault = (state_q == S_RESP) && fault_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: one zero-wait and one three-wait instance checked against a
// byte-addressed reference memory with directed and random accesses.
module tb_dmem_bridge;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 64;
  localparam int          BYTES = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  int          sel;

  logic        req0, req1;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, fault0, fault1, busy0, busy1;
  logic [31:0] rdataS;
  logic        readyS, faultS, busyS;

  assign req0   = req & (sel == 0);
  assign req1   = req & (sel == 1);
  assign rdataS = (sel == 0) ? rdata0 : rdata1;
  assign readyS = (sel == 0) ? ready0 : ready1;
  assign faultS = (sel == 0) ? fault0 : fault1;
  assign busyS  = (sel == 0) ? busy0  : busy1;

  dmem_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk_in(clk), .reset(rst_n), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .fault(fault0), .busy(busy0)
  );

  dmem_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk_in(clk), .reset(rst_n), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .ready(ready1), .fault(fault1), .busy(busy1)
  );

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  mm [2][BYTES];
  logic [31:0] mRdata [2];
  int          mWs [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, faults decided from the address rules directly.
  task automatic modelAccess(input int inst, input bit w, input logic [1:0] sz, input bit sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             output bit eFault, output int eCycle);
    logic [31:0] off;
    logic [31:0] v;
    int          n;
    off    = a - BASE;
    eFault = (sz == 2'b11) || (off >= BYTES) || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00);
    eCycle = eFault ? 1 : mWs[inst] + 2;
    if (!eFault) begin
      n = 1 << sz;
      if (w) begin
        for (int i = 0; i < n; i++)
          mm[inst][int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mm[inst][int'(off) + i]) << (8 * i));
        if (sx && n < 4 && v[8*n-1])
          v = v | (32'hFFFF_FFFF << (8 * n));
        mRdata[inst] = v;
      end
    end
  endtask

  task automatic doAccess(input bit w, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit pulse,
                          output int rCycle, output logic rFault, output logic [31:0] rRdata,
                          output logic [31:0] busyMask, output logic tail);
    int cyc;
    cyc = 0; rCycle = -1; rFault = 1'b0; rRdata = 32'd0; busyMask = 32'd0;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    while (rCycle < 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (busyS) busyMask[cyc] = 1'b1;
      if (readyS) begin
        rCycle = cyc; rFault = faultS; rRdata = rdataS;
      end else if (pulse) begin
        req = cyc[0]; addr = $urandom; wdata = $urandom; we = 1'($urandom);
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    tail = readyS | faultS | busyS;
  endtask

  task automatic applyStimulus(input int inst, input bit w, input logic [1:0] sz, input bit sx,
                               input logic [31:0] a, input logic [31:0] wd, input bit pulse,
                               input string tag, output logic [31:0] rd);
    bit          eFault;
    int          eCycle, rCycle;
    logic        rFault, tail;
    logic [31:0] busyMask, expMask;
    sel = inst;
    #1;
    modelAccess(inst, w, sz, sx, a, wd, eFault, eCycle);
    doAccess(w, sz, sx, a, wd, pulse, rCycle, rFault, rd, busyMask, tail);
    expMask = 32'd0;
    for (int c = 1; c <= eCycle; c++) expMask[c] = 1'b1;
    checkOutput({tag, " ready cycle"}, 32'(rCycle), 32'(eCycle));
    checkOutput({tag, " fault"}, {31'd0, rFault}, {31'd0, eFault});
    checkOutput({tag, " rdata"}, rd, mRdata[inst]);
    checkOutput({tag, " busy cycles"}, busyMask, expMask);
    checkOutput({tag, " idle after"}, {31'd0, tail}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          r;
    sel = 0; rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    mWs[0] = 0; mWs[1] = 3; mRdata[0] = 32'd0; mRdata[1] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      checkOutput("reset rdata", rdataS, 32'd0);
      checkOutput("reset ready", {31'd0, readyS}, 32'd0);
      checkOutput("reset fault", {31'd0, faultS}, 32'd0);
      checkOutput("reset busy",  {31'd0, busyS},  32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++)
      for (int wd = 0; wd < DEPTH; wd++)
        applyStimulus(s, 1'b1, 2'b10, 1'b0, BASE + 32'(4 * wd), $urandom, 1'b0, "init", rd);

    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, "t1 store", rd);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 1'b0, "t1 load", rd);
    checkOutput("t1 value", rd, 32'hDEAD_BEEF);

    applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h1001_0005, 32'h0000_00AA, 1'b0, "t2 sb", rd);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 1'b0, "t2 lw", rd);
    checkOutput("t2 lw value", rd, 32'hDEAD_AAEF);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h1001_0005, 32'd0, 1'b0, "t2 lb", rd);
    checkOutput("t2 lb value", rd, 32'hFFFF_FFAA);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h1001_0005, 32'd0, 1'b0, "t2 lbu", rd);
    checkOutput("t2 lbu value", rd, 32'h0000_00AA);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'd0, 1'b0, "t2 lh", rd);
    checkOutput("t2 lh value", rd, 32'hFFFF_DEAD);

    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'd0, 1'b0, "t3 lw misalign", rd);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h1001_0006, 32'h1111_1111, 1'b0, "t3 sw misalign", rd);
    applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h1001_0005, 32'h2222_2222, 1'b0, "t3 sh misalign", rd);
    applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h1000_FFFC, 32'h3333_3333, 1'b0, "t3 below base", rd);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, BASE + 32'(BYTES), 32'd0, 1'b0, "t3 past end", rd);
    applyStimulus(0, 1'b1, 2'b11, 1'b0, 32'h1001_0004, 32'h4444_4444, 1'b0, "t3 size11", rd);
    checkOutput("t3 rdata kept", rd, 32'hFFFF_DEAD);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 1'b0, "t3 followup", rd);
    checkOutput("t3 no write", rd, 32'hDEAD_AAEF);

    applyStimulus(1, 1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'hCAFE_F00D, 1'b0, "t4 store", rd);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, 1'b1, "t4 load pulses", rd);
    checkOutput("t4 value", rd, 32'hCAFE_F00D);

    sel = 1; #1;
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
    addr = BASE + 32'd16; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5 busy in wait", {31'd0, busyS}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 ready on reset", {31'd0, readyS}, 32'd0);
    checkOutput("t5 fault on reset", {31'd0, faultS}, 32'd0);
    checkOutput("t5 busy on reset",  {31'd0, busyS},  32'd0);
    checkOutput("t5 rdata on reset", rdataS, 32'd0);
    mRdata[0] = 32'd0; mRdata[1] = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1, 1'b0, 2'b10, 1'b0, BASE + 32'd16, 32'd0, 1'b0, "t5 old value", rd);

    for (int s = 0; s < 2; s++) begin
      applyStimulus(s, 1'b1, 2'b10, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A_C3C3, 1'b0,
                    "t6 store last", rd);
      applyStimulus(s, 1'b0, 2'b10, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'd0, 1'b0,
                    "t6 load last", rd);
      checkOutput("t6 value", rd, 32'h5A5A_C3C3);
    end

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else if (r == 1)
        a = BASE + 32'(BYTES) + 32'($urandom_range(0, 15));
      else
        a = BASE + 32'($urandom_range(0, BYTES - 1));
      applyStimulus($urandom_range(0, 1), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                    a, $urandom, 1'($urandom), "rand", rd);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
